edge_detect_multi: RTL

//  Parametrised multi-channel edge detector, successor to the single-bit pos_edge block.

---
 rtl/edge_detect_multi.sv | 138 +++++++++++++
 1 files changed

// File: rtl/edge_detect_multi.sv
// rtl/edge_detect_multi.sv - multi-channel synchronised edge detector with sticky flags and saturating counters; optional GLITCH_FILTER_EN input filter
module edge_detect_multi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 4,
  parameter int FILT_CYCLES = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WIDTH-1:0]         data,
  input  logic [1:0]               mode,
  input  logic                     en,
  input  logic [WIDTH-1:0]         clr,
  output logic [WIDTH-1:0]         pos_edge,
  output logic [WIDTH-1:0]         sticky,
  output logic                     any_edge,
  output logic [WIDTH*CNT_W-1:0]   cnt
);

`ifdef GLITCH_FILTER_EN
  localparam int FILT_USED = 1;
`else
  localparam int FILT_USED = 0;
`endif

  // Detection stays off until the sync chain, optional filter and prev flop hold real samples.
  localparam int PRIME_LEN = SYNC_STAGES + 1 + FILT_USED * FILT_CYCLES;
  localparam int PRIME_W   = $clog2(PRIME_LEN + 1);

  logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]   s;
  logic [WIDTH-1:0]   level;
  logic [WIDTH-1:0]   prev_q;
  logic [WIDTH-1:0]   rise;
  logic [WIDTH-1:0]   fall;
  logic [WIDTH-1:0]   pulse_next;
  logic [PRIME_W-1:0] prime_cnt;
  logic               primed;

  // Synchroniser chain per channel; stage 0 samples the asynchronous pads.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= data;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef GLITCH_FILTER_EN
  localparam int FILT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  logic [FILT_W-1:0] filt_cnt [WIDTH];
  logic [WIDTH-1:0]  filt_q;

  // A new level is accepted only after FILT_CYCLES consecutive samples disagree with the held one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      filt_q <= '0;
      for (int i = 0; i < WIDTH; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s[i] == filt_q[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FILT_W'(FILT_CYCLES - 1)) begin
          filt_q[i]   <= s[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level = filt_q;
`else
  assign level = s;
`endif

  // prev tracks the level every cycle, even while disabled, so re-enabling never sees a stale edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prev_q <= '0;
    else       prev_q <= level;
  end

  // Priming counter counts up once after reset release and then parks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        prime_cnt <= '0;
    else if (!primed) prime_cnt <= prime_cnt + 1'b1;
  end

  assign primed = (prime_cnt == PRIME_W'(PRIME_LEN));
  assign rise   = level & ~prev_q;
  assign fall   = ~level & prev_q;

  // Next pulse vector: gated by enable, priming and the requested edge polarity.
  always_comb begin
    pulse_next = '0;
    if (en && primed) begin
      pulse_next = ({WIDTH{mode[0]}} & rise) | ({WIDTH{mode[1]}} & fall);
    end
  end

  // Pulse and its OR come from the same next-state so they are coincident.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos_edge <= '0;
      any_edge <= 1'b0;
    end else begin
      pos_edge <= pulse_next;
      any_edge <= |pulse_next;
    end
  end

  // Sticky flags: a pulse beats a simultaneous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sticky <= '0;
    else       sticky <= pos_edge | (sticky & ~clr);
  end

  // Saturating per-channel event counters; clear with a coincident pulse leaves a count of one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (clr[i]) begin
          cnt[i*CNT_W +: CNT_W] <= pos_edge[i] ? CNT_W'(1) : '0;
        end else if (pos_edge[i] && (cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          cnt[i*CNT_W +: CNT_W] <= cnt[i*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

endmodule
